// File: rtl/three_operand_loader.sv
// three_operand_loader
//   Collects three WIDTH-bit operands from one shared valid/ready input bus
//   and presents them in parallel on a/b/c. The outputs stay stable with
//   ops_valid high until the downstream adder returns ops_ack.
//
//   Optional feature (macro LOADER_TIMEOUT_EN): a partial load that stalls
//   in S_B or S_C for TIMEOUT_CYCLES consecutive edges is aborted. The
//   operands are zeroed and timeout_err pulses for one cycle. Without the
//   macro, no counter is built and a partial load waits indefinitely.

module three_operand_loader #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             ops_valid,
  input  logic             ops_ack,
  output logic [1:0]       load_count,
  output logic             timeout_err
);

  // The encoding is visible on load_count, so the values are fixed.
  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_C    = 2'd2,
    S_FULL = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic xfer;      // a din transfer happens on this edge
  logic load_a;
  logic load_b;
  logic load_c;
  logic zero_ops;  // clear or timeout: drop the partial load
  logic tmo_fire;  // timeout abort on this edge

  // Fail elaboration if the stall limit is meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("three_operand_loader: TIMEOUT_CYCLES must be >= 1");
  end

  // Handshake outputs come from the state register only. There is no
  // combinational path from din_valid to din_ready.
  assign din_ready  = (state != S_FULL);
  assign ops_valid  = (state == S_FULL);
  assign load_count = state;
  assign xfer       = din_valid && din_ready;

`ifdef LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             stalling;

  // Stalled means: mid-load, no transfer, and no clear on this edge.
  // Every way of leaving S_B/S_C is a transfer, a clear or a timeout, so
  // clearing the count on those events also clears it on every state change.
  assign stalling = ((state == S_B) || (state == S_C)) && !xfer && !clear;

  // The count holds the number of stalled edges already seen. The edge that
  // finds TIMEOUT_CYCLES-1 is therefore the TIMEOUT_CYCLES-th stalled edge.
  assign tmo_fire = stalling && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled edges. Restart from zero on anything else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stalling && !tmo_fire) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  // Register the abort so the error pulse lands in the cycle after the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples
  // pre-edge values. Blocking here would create ordering-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and load-enable decode. clear beats timeout, and timeout beats
  // normal sequencing. A transfer on the timeout edge never fires, because a
  // transfer means the loader is not stalling.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned. An unassigned path would infer a latch.
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_c    = 1'b0;
    zero_ops  = 1'b0;

    if (clear || tmo_fire) begin
      state_nxt = S_A;
      zero_ops  = 1'b1;
    end else begin
      unique case (state)
        S_A: if (xfer) begin
          load_a    = 1'b1;
          state_nxt = S_B;
        end
        S_B: if (xfer) begin
          load_b    = 1'b1;
          state_nxt = S_C;
        end
        S_C: if (xfer) begin
          load_c    = 1'b1;
          state_nxt = S_FULL;
        end
        S_FULL: if (ops_ack) begin
          state_nxt = S_A;
        end
        default: state_nxt = S_A;
      endcase
    end
  end

  // Operand registers. They hold unless loaded or zeroed, which keeps them
  // frozen in S_FULL and after ack until the next load overwrites them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the operand registers are only three words of flops, not a
      // memory. They get a real reset, so a/b/c read 0 out of reset.
      a <= '0;
      b <= '0;
      c <= '0;
    end else if (zero_ops) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else begin
      if (load_a) a <= din;
      if (load_b) b <= din;
      if (load_c) c <= din;
    end
  end

endmodule

// File: tb/tb_three_operand_loader.sv
// Testbench for three_operand_loader.
// Stimulus drives directed vectors and pushes each expected operand triple
// into a queue. A monitor pops one triple each time ops_valid rises, and it
// checks that a/b/c hold steady while ops_valid stays high.

module tb_three_operand_loader;

  localparam int WIDTH = 8;
  localparam int TMO   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             ops_valid;
  logic             ops_ack;
  logic [1:0]       load_count;
  logic             timeout_err;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } triple_t;

  triple_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  bit      done   = 1'b0;

  three_operand_loader #(
    .WIDTH         (WIDTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .clear      (clear),
    .a          (a),
    .b          (b),
    .c          (c),
    .ops_valid  (ops_valid),
    .ops_ack    (ops_ack),
    .load_count (load_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge. Inputs are driven and outputs are sampled 1 time unit
  // after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and let one edge pass.
  task automatic send(input logic [WIDTH-1:0] d);
    din       = d;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic ack();
    ops_ack = 1'b1;
    step();
    ops_ack = 1'b0;
  endtask

  // Monitor: one pop per ops_valid rising edge, and a hold check every cycle
  // that ops_valid stays high.
  initial begin : monitor
    triple_t cur;
    bit      prev_valid;
    prev_valid = 1'b0;
    cur        = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (ops_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ops_valid", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        if (ops_valid) begin
          check("sb_a", {24'd0, a}, {24'd0, cur.a});
          check("sb_b", {24'd0, b}, {24'd0, cur.b});
          check("sb_c", {24'd0, c}, {24'd0, cur.c});
        end
        prev_valid = ops_valid;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin : stimulus
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    clear     = 1'b0;
    ops_ack   = 1'b0;
    #1;
    check("rst_din_ready",  {31'd0, din_ready},  32'd1);
    check("rst_ops_valid",  {31'd0, ops_valid},  32'd0);
    check("rst_load_count", {30'd0, load_count}, 32'd0);
    check("rst_timeout",    {31'd0, timeout_err}, 32'd0);
    check("rst_a", {24'd0, a}, 32'd0);
    #22;
    reset = 1'b0;
    step();

    // Three back-to-back loads.
    exp_q.push_back('{a: 8'h11, b: 8'h22, c: 8'h33});
    din_valid = 1'b1;
    din = 8'h11; step();
    din = 8'h22; step();
    din = 8'h33; step();
    din_valid = 1'b0;
    check("full_ops_valid", {31'd0, ops_valid},  32'd1);
    check("full_din_ready", {31'd0, din_ready},  32'd0);
    check("full_count",     {30'd0, load_count}, 32'd3);

    // din_valid is ignored in S_FULL.
    din       = 8'hFF;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_count", {30'd0, load_count}, 32'd3);
      check("hold_a", {24'd0, a}, 32'h11);
      check("hold_c", {24'd0, c}, 32'h33);
    end
    din_valid = 1'b0;
    ack();
    check("ack_count",     {30'd0, load_count}, 32'd0);
    check("ack_ops_valid", {31'd0, ops_valid},  32'd0);
    check("ack_din_ready", {31'd0, din_ready},  32'd1);
    check("ack_keep_a",    {24'd0, a},          32'h11);
    check("ack_keep_b",    {24'd0, b},          32'h22);

    // clear with a simultaneous transfer.
    send(8'h01);
    send(8'h02);
    check("pre_clear_count", {30'd0, load_count}, 32'd2);
    din       = 8'h03;
    din_valid = 1'b1;
    clear     = 1'b1;
    step();
    clear     = 1'b0;
    din_valid = 1'b0;
    check("clear_count", {30'd0, load_count}, 32'd0);
    check("clear_a", {24'd0, a}, 32'd0);
    check("clear_b", {24'd0, b}, 32'd0);
    check("clear_c", {24'd0, c}, 32'd0);
    step();
    check("clear_no_capture", {24'd0, a}, 32'd0);

    // Asynchronous reset mid-cycle while in S_C.
    send(8'h44);
    send(8'h55);
    check("pre_rst_count", {30'd0, load_count}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ops_valid", {31'd0, ops_valid},  32'd0);
    check("arst_din_ready", {31'd0, din_ready},  32'd1);
    check("arst_count",     {30'd0, load_count}, 32'd0);
    check("arst_a",         {24'd0, a},          32'd0);
    #2;
    reset = 1'b0;
    step();

    // Gapped din_valid: idle cycles do not advance the state.
    exp_q.push_back('{a: 8'h07, b: 8'h08, c: 8'h09});
    send(8'h07); check("gap_c1", {30'd0, load_count}, 32'd1);
    step();      check("gap_c2", {30'd0, load_count}, 32'd1);
    send(8'h08); check("gap_c3", {30'd0, load_count}, 32'd2);
    step();      check("gap_c4", {30'd0, load_count}, 32'd2);
    send(8'h09); check("gap_c5", {30'd0, load_count}, 32'd3);
    step();
    ack();

    // Back-to-back triple at best-case throughput.
    exp_q.push_back('{a: 8'hA1, b: 8'hB2, c: 8'hC3});
    send(8'hA1);
    send(8'hB2);
    send(8'hC3);
    ack();
    check("tput_count", {30'd0, load_count}, 32'd0);

    // clear together with ack in S_FULL acts as clear alone.
    exp_q.push_back('{a: 8'h5A, b: 8'hA5, c: 8'h3C});
    send(8'h5A);
    send(8'hA5);
    send(8'h3C);
    step();
    clear   = 1'b1;
    ops_ack = 1'b1;
    step();
    clear   = 1'b0;
    ops_ack = 1'b0;
    check("clr_ack_count", {30'd0, load_count}, 32'd0);
    check("clr_ack_a",     {24'd0, a},          32'd0);
    check("clr_ack_c",     {24'd0, c},          32'd0);

`ifdef LOADER_TIMEOUT_EN
    // Stall in S_B for TMO edges: the load aborts.
    send(8'hAA);
    for (int i = 1; i < TMO; i++) begin
      step();
      check("tmo_wait_err",   {31'd0, timeout_err}, 32'd0);
      check("tmo_wait_count", {30'd0, load_count},  32'd1);
    end
    step();
    check("tmo_err",   {31'd0, timeout_err}, 32'd1);
    check("tmo_count", {30'd0, load_count},  32'd0);
    check("tmo_a",     {24'd0, a},           32'd0);
    step();
    check("tmo_pulse_end", {31'd0, timeout_err}, 32'd0);

    // A transfer on the TMO-th edge wins over the timeout.
    send(8'hAA);
    for (int i = 1; i < TMO; i++) step();
    send(8'hBB);
    check("tmo_win_count", {30'd0, load_count},  32'd2);
    check("tmo_win_b",     {24'd0, b},           32'hBB);
    check("tmo_win_err",   {31'd0, timeout_err}, 32'd0);
    step();
    check("tmo_win_err2",  {31'd0, timeout_err}, 32'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
`else
    // Without the timeout a partial load waits indefinitely.
    send(8'hAA);
    for (int i = 0; i < 300; i++) step();
    check("notmo_count", {30'd0, load_count},  32'd1);
    check("notmo_err",   {31'd0, timeout_err}, 32'd0);
    check("notmo_a",     {24'd0, a},           32'hAA);
    clear = 1'b1;
    step();
    clear = 1'b0;
`endif

    step();
    step();
    check("queue_drained", exp_q.size(), 32'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
